// File: rtl/bcd_updown_cnt.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bcd_updown_cnt : multi-digit BCD up/down counter with load/wrap/flags   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module bcd_updown_cnt #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] RST_VAL = 'h30
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  load,
  input  logic                  up,
  input  logic                  wrap,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  done,
  output logic                  wrapped,
  output logic                  err
);

  localparam int              c_W    = 4 * DIGITS;
  localparam logic [c_W-1:0]  c_ALL9 = {DIGITS{4'h9}};

  logic [c_W-1:0]    r_cnt;
  logic              r_done;
  logic              r_wrapped;
  logic              r_err;

  logic [c_W-1:0]    w_load_val;
  logic [c_W-1:0]    w_inc;
  logic [c_W-1:0]    w_dec;
  logic [c_W-1:0]    w_step;
  logic [c_W-1:0]    w_term;
  logic [DIGITS-1:0] w_bad;
  logic [DIGITS-1:0] w_inc_c;
  logic [DIGITS-1:0] w_dec_c;
  logic              w_at_term;
  logic              w_step_term;

  assign w_inc_c[0] = 1'b1;
  assign w_dec_c[0] = 1'b1;

  // Per-digit load clamp plus single-cycle carry/borrow ripple
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_din;
    assign w_dig    = r_cnt[4*i +: 4];
    assign w_din    = data[4*i +: 4];
    assign w_bad[i] = (w_din > 4'd9);
    assign w_load_val[4*i +: 4] = w_bad[i] ? 4'd9 : w_din;
    assign w_inc[4*i +: 4] = !w_inc_c[i] ? w_dig : (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
    assign w_dec[4*i +: 4] = !w_dec_c[i] ? w_dig : (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
    if (i < DIGITS - 1) begin : g_chain
      assign w_inc_c[i+1] = w_inc_c[i] & (w_dig == 4'd9);
      assign w_dec_c[i+1] = w_dec_c[i] & (w_dig == 4'd0);
    end
  end

  // At an extreme the ripple already produces the opposite extreme
  assign w_step      = up ? w_inc : w_dec;
  assign w_term      = up ? c_ALL9 : '0;
  assign w_at_term   = (r_cnt == w_term);
  assign w_step_term = (w_step == w_term);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt     <= RST_VAL;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
    end else if (load) begin
      r_cnt     <= w_load_val;
      r_err     <= |w_bad;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (en) begin
      if (w_at_term) begin
        if (wrap) begin
          r_cnt <= w_step;
        end
        r_wrapped <= wrap;
        r_done    <= 1'b0;
      end else begin
        r_cnt     <= w_step;
        r_done    <= w_step_term;
        r_wrapped <= 1'b0;
      end
    end else begin
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end
  end

  assign cnt     = r_cnt;
  assign tc      = rstn & w_at_term;
  assign done    = r_done;
  assign wrapped = r_wrapped;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_cnt.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_bcd_updown_cnt : directed self-checking bench for bcd_updown_cnt     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_bcd_updown_cnt;

  logic       clk = 1'b0;
  logic       rstn, en, load, up, wrap;
  logic [7:0] data;
  logic [7:0] cnt;
  logic       tc, done, wrapped, err;
  int         checks = 0;
  int         errors = 0;

  bcd_updown_cnt #(.DIGITS(2), .RST_VAL(8'h30)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .up(up), .wrap(wrap),
    .data(data), .cnt(cnt), .tc(tc), .done(done), .wrapped(wrapped), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; load = 1'b0; up = 1'b0; wrap = 1'b0; data = 8'h00;
    step();
    checks++; if (cnt !== 8'h30) begin errors++; $display("FAIL reset_cnt got %h exp 30", cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %b exp 0", wrapped); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc); end
  endtask

  task automatic test_count_down();
    rstn = 1'b1; up = 1'b0; en = 1'b1; wrap = 1'b0;
    for (int e = 29; e >= 0; e--) begin
      step();
      checks++; if (cnt !== bcd(e)) begin errors++; $display("FAIL down_cnt got %h exp %h", cnt, bcd(e)); end
      checks++; if (done !== (e == 0)) begin errors++; $display("FAIL down_done at %0d got %b exp %b", e, done, (e == 0)); end
    end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_tc got %b exp 1", tc); end
  endtask

  task automatic test_wrap_down();
    wrap = 1'b0; en = 1'b1; up = 1'b0;
    step();
    checks++; if (cnt !== 8'h00) begin errors++; $display("FAIL sat_cnt got %h exp 00", cnt); end
    checks++; if (wrapped !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL sat_pulses got w=%b d=%b exp 0 0", wrapped, done); end
    wrap = 1'b1;
    step();
    checks++; if (cnt !== 8'h99) begin errors++; $display("FAIL wrapdn_cnt got %h exp 99", cnt); end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrapdn_wrapped got %b exp 1", wrapped); end
    en = 1'b0;
    step();
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrapdn_pulse got %b exp 0", wrapped); end
    checks++; if (cnt !== 8'h99) begin errors++; $display("FAIL hold_cnt got %h exp 99", cnt); end
  endtask

  task automatic test_load_carry();
    load = 1'b1; data = 8'h09; up = 1'b1; en = 1'b0;
    step();
    checks++; if (cnt !== 8'h09) begin errors++; $display("FAIL load09_cnt got %h exp 09", cnt); end
    load = 1'b0; en = 1'b1;
    step();
    checks++; if (cnt !== 8'h10) begin errors++; $display("FAIL carry_cnt got %h exp 10", cnt); end
    load = 1'b1; data = 8'h98; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; wrap = 1'b1;
    step();
    checks++; if (cnt !== 8'h99 || done !== 1'b1) begin errors++; $display("FAIL up99 got cnt=%h done=%b exp 99 1", cnt, done); end
    step();
    checks++; if (cnt !== 8'h00 || wrapped !== 1'b1) begin errors++; $display("FAIL wrapup got cnt=%h w=%b exp 00 1", cnt, wrapped); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrapup_done got %b exp 0", done); end
  endtask

  task automatic test_err();
    en = 1'b0; load = 1'b1; data = 8'h3C;
    step();
    checks++; if (cnt !== 8'h39 || err !== 1'b1) begin errors++; $display("FAIL err_set got cnt=%h err=%b exp 39 1", cnt, err); end
    load = 1'b0;
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    load = 1'b1; data = 8'h45;
    step();
    checks++; if (cnt !== 8'h45 || err !== 1'b0) begin errors++; $display("FAIL err_clr got cnt=%h err=%b exp 45 0", cnt, err); end
    load = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; en = 1'b1; up = 1'b1; data = 8'h99;
    step();
    checks++; if (cnt !== 8'h99 || done !== 1'b0 || wrapped !== 1'b0) begin
      errors++; $display("FAIL loadwin got cnt=%h d=%b w=%b exp 99 0 0", cnt, done, wrapped);
    end
    rstn = 1'b0; load = 1'b1; data = 8'hF0; en = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_in_rst got %b exp 0", tc); end
    step();
    checks++; if (cnt !== 8'h30 || err !== 1'b0 || tc !== 1'b0) begin
      errors++; $display("FAIL rst_over_load got cnt=%h err=%b tc=%b exp 30 0 0", cnt, err, tc);
    end
    rstn = 1'b1; load = 1'b0; up = 1'b1;
    step();
    checks++; if (cnt !== 8'h31) begin errors++; $display("FAIL resume_cnt got %h exp 31", cnt); end
  endtask

  task automatic test_up_toggle();
    load = 1'b1; data = 8'h99; en = 1'b0; up = 1'b1;
    step();
    load = 1'b0;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL tc_up got %b exp 1", tc); end
    up = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_toggle got %b exp 0", tc); end
    en = 1'b1;
    step();
    checks++; if (cnt !== 8'h98) begin errors++; $display("FAIL toggle_cnt got %h exp 98", cnt); end
    up = 1'b1;
    step();
    checks++; if (cnt !== 8'h99 || done !== 1'b1) begin errors++; $display("FAIL back_up got cnt=%h done=%b exp 99 1", cnt, done); end
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_wrap_down();
    test_load_carry();
    test_err();
    test_load_priority();
    test_up_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
